// File: rtl/dla_hld_ram_arb_pkg.sv
// Shared types and helpers for the dla_hld_ram port arbiter and its round-robin core.
package dla_hld_ram_arb_pkg;

    // Top-level operating mode: normal arbitration or memory zero-fill
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Widest requester ID ever needed (NUM_REQ tops out at 8)
    localparam int MAX_ID_W = 3;

    // One stage of the read-response ID pipeline
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rsp_stage_t;

    // Requester ID width, never narrower than one bit
    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/dla_hld_ram_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
module dla_hld_ram_rr_arbiter
    import dla_hld_ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;

    // Search from the pointer, wrapping once, and grant the first active request
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sel      = '0;
        idx      = 0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                sel = ID_W'(idx);
                if (!found && req[sel]) begin
                    found      = 1'b1;
                    grant[sel] = 1'b1;
                    grant_id   = sel;
                end
            end
        end
    end

    // A grant is always taken (requests hold until granted), so move past the winner
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/dla_hld_ram_port_arbiter.sv
// Shares one dla_hld_ram port between NUM_REQ requesters, routes read responses
// back by ID and can zero-fill the whole memory on command.
module dla_hld_ram_port_arbiter
    import dla_hld_ram_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DEPTH        = 1024,
    parameter  int WIDTH        = 40,
    parameter  int BE_WIDTH     = 4,
    parameter  int READ_LATENCY = 3,
    localparam int ADDR         = $clog2(DEPTH),
    localparam int ID           = id_width(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        clear_start,
    output logic                        clear_busy,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR-1:0]     req_address,
    input  logic [NUM_REQ*WIDTH-1:0]    req_writedata,
    input  logic [NUM_REQ*BE_WIDTH-1:0] req_byteenable,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [WIDTH-1:0]            rsp_readdata,
    output logic [ADDR-1:0]             ram_address,
    output logic                        ram_read_enable,
    output logic                        ram_write,
    output logic [WIDTH-1:0]            ram_writedata,
    output logic [BE_WIDTH-1:0]         ram_byteenable,
    input  logic [WIDTH-1:0]            ram_readdata
);

    arb_state_t                  state;
    arb_state_t                  state_next;
    logic [ADDR-1:0]             clear_addr;
    logic                        clear_last;
    logic                        arb_enable;
    logic [NUM_REQ-1:0]          grant;
    logic [ID-1:0]               grant_id;
    logic                        accept;
    logic                        acc_write;
    logic [ADDR-1:0]             acc_addr;
    logic [WIDTH-1:0]            acc_data;
    logic [BE_WIDTH-1:0]         acc_be;
    rsp_stage_t                  pipe_in;
    rsp_stage_t [READ_LATENCY:0] pipe;
    logic [NUM_REQ-1:0]          rsp_valid_next;

    // Grants are suppressed while clearing and while reset is held
    assign arb_enable = (state == ARB) && resetn;
    assign req_ready  = grant;
    assign accept     = |grant;
    assign clear_busy = (state == CLEAR);
    assign clear_last = (clear_addr == ADDR'(DEPTH - 1));

    dla_hld_ram_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clock    (clock),
        .resetn   (resetn),
        .req      (req_valid),
        .enable   (arb_enable),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Pick the granted requester's command fields off the packed buses
    always_comb begin
        acc_write = req_write[grant_id];
        acc_addr  = req_address[int'(grant_id)*ADDR +: ADDR];
        acc_data  = req_writedata[int'(grant_id)*WIDTH +: WIDTH];
        acc_be    = req_byteenable[int'(grant_id)*BE_WIDTH +: BE_WIDTH];
    end

    // Mode sequencing: enter CLEAR after a start request, leave after the last address
    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (clear_start) state_next = CLEAR;
            CLEAR:   if (clear_last)  state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // State register and clear address counter; the counter rewinds to 0 on exit so it never wraps
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ARB;
            clear_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clear_addr <= clear_last ? '0 : clear_addr + 1'b1;
            end
        end
    end

    // Registered RAM command: clear writes take priority, otherwise the accepted request
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ram_address     <= '0;
            ram_read_enable <= 1'b0;
            ram_write       <= 1'b0;
            ram_writedata   <= '0;
            ram_byteenable  <= '0;
        end else begin
            ram_write       <= 1'b0;
            ram_read_enable <= 1'b0;
            if (state == CLEAR) begin
                ram_write      <= 1'b1;
                ram_address    <= clear_addr;
                ram_writedata  <= '0;
                ram_byteenable <= '1;
            end else if (accept) begin
                ram_address <= acc_addr;
                if (acc_write) begin
                    ram_write      <= 1'b1;
                    ram_writedata  <= acc_data;
                    ram_byteenable <= acc_be;
                end else begin
                    ram_read_enable <= 1'b1;
                    ram_writedata   <= '0;
                    ram_byteenable  <= '0;
                end
            end
        end
    end

    // Tag entering the ID pipeline for each accepted read
    always_comb begin
        pipe_in.valid = accept && !acc_write;
        pipe_in.id    = MAX_ID_W'(grant_id);
    end

    // ID pipeline: the last stage lines up with valid ram_readdata
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[READ_LATENCY-1:0], pipe_in};
        end
    end

    // Decode the returning ID into a one-hot response valid
    always_comb begin
        rsp_valid_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_next[i] = pipe[READ_LATENCY].valid &&
                                (pipe[READ_LATENCY].id == MAX_ID_W'(i));
        end
    end

    // Response register: read data is captured only when a response is due
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsp_valid    <= '0;
            rsp_readdata <= '0;
        end else begin
            rsp_valid <= rsp_valid_next;
            if (pipe[READ_LATENCY].valid) begin
                rsp_readdata <= ram_readdata;
            end
        end
    end

endmodule

// File: tb/tb_dla_hld_ram_port_arbiter.sv
// Self-checking bench for dla_hld_ram_port_arbiter with a behavioural RAM and response scoreboard.
module tb_dla_hld_ram_port_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DEPTH        = 1536;
    localparam int WIDTH        = 40;
    localparam int BE_WIDTH     = 4;
    localparam int READ_LATENCY = 3;
    localparam int ADDR         = 11;

    logic                        clock;
    logic                        resetn;
    logic                        clear_start;
    logic                        clear_busy;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ*ADDR-1:0]     req_address;
    logic [NUM_REQ*WIDTH-1:0]    req_writedata;
    logic [NUM_REQ*BE_WIDTH-1:0] req_byteenable;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [WIDTH-1:0]            rsp_readdata;
    logic [ADDR-1:0]             ram_address;
    logic                        ram_read_enable;
    logic                        ram_write;
    logic [WIDTH-1:0]            ram_writedata;
    logic [BE_WIDTH-1:0]         ram_byteenable;
    logic [WIDTH-1:0]            ram_readdata;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    typedef struct {
        int                  rid;
        logic                wr;
        logic [ADDR-1:0]     addr;
        logic [WIDTH-1:0]    wdata;
        logic [BE_WIDTH-1:0] be;
        logic [WIDTH-1:0]    exp_rdata;
    } vec_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    vec_t             vecs[7];
    logic [WIDTH-1:0] ram_mem [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] rd_pipe [READ_LATENCY];
    int               total;
    int               bad;
    int               cyc;

    dla_hld_ram_port_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DEPTH        (DEPTH),
        .WIDTH        (WIDTH),
        .BE_WIDTH     (BE_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .clear_start     (clear_start),
        .clear_busy      (clear_busy),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_writedata   (req_writedata),
        .req_byteenable  (req_byteenable),
        .rsp_valid       (rsp_valid),
        .rsp_readdata    (rsp_readdata),
        .ram_address     (ram_address),
        .ram_read_enable (ram_read_enable),
        .ram_write       (ram_write),
        .ram_writedata   (ram_writedata),
        .ram_byteenable  (ram_byteenable),
        .ram_readdata    (ram_readdata)
    );

    function automatic logic [WIDTH-1:0] init_val(input int a);
        return {8'hA5, 21'h0, 11'(a)};
    endfunction

    // Free-running clock and cycle counter used to time responses
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural RAM: byte-lane writes, reads visible READ_LATENCY cycles after read enable
    always @(posedge clock) begin
        if (ram_write) begin
            for (int j = 0; j < BE_WIDTH; j++) begin
                if (ram_byteenable[j]) ram_mem[ram_address][j*10 +: 10] <= ram_writedata[j*10 +: 10];
            end
        end
        if (ram_read_enable) rd_pipe[0] <= ram_mem[ram_address];
        for (int s = 1; s < READ_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    assign ram_readdata = rd_pipe[READ_LATENCY-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Response monitor: every rsp_valid pops the oldest expected response
    always @(negedge clock) begin
        if (rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rsp_unexpected actual=0x%0h required=0x0", rsp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(1 << mon_e.id));
                checkOutput("rsp_readdata", 64'(rsp_readdata), 64'(mon_e.data));
                checkOutput("rsp_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Called at negedge: find the accepted requester, update the reference memory or queue the read
    task automatic sampleAccept(input logic use_ovr, input logic [WIDTH-1:0] ovr, output int idx);
        exp_t            e;
        logic [ADDR-1:0] a;
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && idx < 0) idx = i;
        end
        if (idx >= 0) begin
            a = req_address[idx*ADDR +: ADDR];
            if (req_write[idx]) begin
                for (int j = 0; j < BE_WIDTH; j++) begin
                    if (req_byteenable[idx*BE_WIDTH + j])
                        ref_mem[a][j*10 +: 10] = req_writedata[idx*WIDTH + j*10 +: 10];
                end
            end else begin
                e.id   = idx;
                e.data = use_ovr ? ovr : ref_mem[a];
                e.due  = cyc + 2 + READ_LATENCY;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic setReq(input int rid, input logic wr, input logic [ADDR-1:0] addr,
                          input logic [WIDTH-1:0] wd, input logic [BE_WIDTH-1:0] be);
        req_write[rid]                         = wr;
        req_address[rid*ADDR +: ADDR]          = addr;
        req_writedata[rid*WIDTH +: WIDTH]      = wd;
        req_byteenable[rid*BE_WIDTH +: BE_WIDTH] = be;
    endtask

    // One single-requester transaction; checks the grant and the RAM command one cycle later
    task automatic applyStimulus(input vec_t v);
        int   idx;
        logic got;
        got = 1'b0;
        @(posedge clock); #1;
        setReq(v.rid, v.wr, v.addr, v.wdata, v.be);
        req_valid        = '0;
        req_valid[v.rid] = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                checkOutput("vec_ready", 64'(req_ready), 64'(1 << v.rid));
                sampleAccept(1'b1, v.exp_rdata, idx);
                got = 1'b1;
            end
        end
        if (!got) failNow("vec_ready_wait");
        @(posedge clock); #1;
        req_valid = '0;
        checkOutput("vec_ram_write", 64'(ram_write), 64'(v.wr));
        checkOutput("vec_ram_read_enable", 64'(ram_read_enable), 64'(!v.wr));
        checkOutput("vec_ram_address", 64'(ram_address), 64'(v.addr));
        checkOutput("vec_ram_writedata", 64'(ram_writedata), v.wr ? 64'(v.wdata) : 64'h0);
        checkOutput("vec_ram_byteenable", 64'(ram_byteenable), v.wr ? 64'(v.be) : 64'h0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'h0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        checkOutput({tag, "_rsp_readdata"}, 64'(rsp_readdata), 64'h0);
        checkOutput({tag, "_clear_busy"}, 64'(clear_busy), 64'h0);
        checkOutput({tag, "_ram_address"}, 64'(ram_address), 64'h0);
        checkOutput({tag, "_ram_read_enable"}, 64'(ram_read_enable), 64'h0);
        checkOutput({tag, "_ram_write"}, 64'(ram_write), 64'h0);
        checkOutput({tag, "_ram_writedata"}, 64'(ram_writedata), 64'h0);
        checkOutput({tag, "_ram_byteenable"}, 64'(ram_byteenable), 64'h0);
    endtask

    // Hard time limit so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        int idx;
        int n;
        int first;
        int busy_cnt;
        int wr_cnt;
        int exp_addr;
        int addr_bad;
        int ready_bad;
        int log_q[$];
        logic hit;
        logic done;

        total = 0; bad = 0; cyc = 0;
        resetn = 1'b0; clear_start = 1'b0;
        req_valid = '0; req_write = '0; req_address = '0;
        req_writedata = '0; req_byteenable = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ram_mem[a] = init_val(a);
            ref_mem[a] = init_val(a);
        end
        for (int s = 0; s < READ_LATENCY; s++) rd_pipe[s] = '0;

        vecs[0] = '{2, 1'b1, 11'd7,  40'hAB_CDEF_0123, 4'b1111, 40'h0};
        vecs[1] = '{1, 1'b0, 11'd7,  40'h0,            4'b0000, 40'hAB_CDEF_0123};
        vecs[2] = '{2, 1'b1, 11'd7,  40'h11_2233_4455, 4'b0001, 40'h0};
        vecs[3] = '{1, 1'b0, 11'd7,  40'h0,            4'b0000, 40'hAB_CDEF_0055};
        vecs[4] = '{0, 1'b1, 11'd20, 40'hFF_FFFF_FFFF, 4'b1010, 40'h0};
        vecs[5] = '{3, 1'b0, 11'd20, 40'h0,            4'b0000, 40'hFF_C00F_FC14};
        vecs[6] = '{0, 1'b0, 11'd11, 40'h0,            4'b0000, 40'hA5_0000_000B};

        // Reset state
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        @(posedge clock); #1;
        resetn = 1'b1;

        // Four simultaneous reads: grants 0,1,2,3 on consecutive cycles
        @(posedge clock); #1;
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 1'b0, ADDR'(10 + i), '0, '0);
        req_valid = '1;
        n = 0; first = 0;
        for (int k = 0; k < 12 && n < 4; k++) begin
            @(negedge clock);
            sampleAccept(1'b0, '0, idx);
            if (idx >= 0) begin
                checkOutput("burst_grant", 64'(idx), 64'(n));
                if (n == 0) first = cyc;
                else checkOutput("burst_cycle", 64'(cyc), 64'(first + n));
                n++;
                @(posedge clock); #1;
                req_valid[idx] = 1'b0;
            end
        end
        if (n != 4) failNow("burst_accepts");
        repeat (10) @(negedge clock);
        checkOutput("burst_drain", 64'(sb_q.size()), 64'h0);

        // Table-driven writes/reads including a partial byte-enable update
        for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);
        repeat (10) @(negedge clock);
        checkOutput("table_drain", 64'(sb_q.size()), 64'h0);

        // Fairness: requester 0 streams, requester 3 joins; grants must alternate
        @(posedge clock); #1;
        setReq(0, 1'b0, 11'd11, '0, '0);
        setReq(3, 1'b0, 11'd12, '0, '0);
        req_valid = 4'b0001;
        for (int k = 0; k < 20 && log_q.size() < 6; k++) begin
            @(negedge clock);
            sampleAccept(1'b0, '0, idx);
            if (idx >= 0) log_q.push_back(idx);
            @(posedge clock); #1;
            req_valid[3] = 1'b1;
            if (log_q.size() >= 6) req_valid = '0;
        end
        checkOutput("fair_count", 64'(log_q.size()), 64'd6);
        for (int k = 0; k < log_q.size(); k++)
            checkOutput("fair_grant", 64'(log_q[k]), (k % 2 == 0) ? 64'd0 : 64'd3);
        repeat (10) @(negedge clock);
        checkOutput("fair_drain", 64'(sb_q.size()), 64'h0);

        // Read accepted in the clear_start cycle returns pre-clear data during the clear
        @(posedge clock); #1;
        setReq(1, 1'b0, 11'd1535, '0, '0);
        req_valid   = 4'b0010;
        clear_start = 1'b1;
        @(negedge clock);
        sampleAccept(1'b1, 40'hA5_0000_05FF, idx);
        checkOutput("clear_read_grant", 64'(idx), 64'd1);
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        @(posedge clock); #1;
        clear_start = 1'b0;
        setReq(2, 1'b0, 11'd1535, '0, '0);
        req_valid = 4'b0100;
        busy_cnt = 0; wr_cnt = 0; exp_addr = 0; addr_bad = 0; ready_bad = 0; done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clock);
            if (ram_write) begin
                if (int'(ram_address) != exp_addr || ram_writedata != '0 || ram_byteenable != 4'hF)
                    addr_bad++;
                exp_addr++;
                wr_cnt++;
            end
            if (!clear_busy) begin
                done = 1'b1;
            end else begin
                busy_cnt++;
                if (req_ready != '0) ready_bad++;
            end
        end
        if (!done) failNow("clear_end");
        checkOutput("clear_busy_cycles", 64'(busy_cnt), 64'd1536);
        checkOutput("clear_write_count", 64'(wr_cnt), 64'd1536);
        checkOutput("clear_addr_errors", 64'(addr_bad), 64'd0);
        checkOutput("clear_ready_seen", 64'(ready_bad), 64'd0);
        checkOutput("clear_last_write", 64'(ram_write), 64'd1);
        checkOutput("clear_last_addr", 64'(ram_address), 64'd1535);
        sampleAccept(1'b0, '0, idx);
        checkOutput("post_clear_grant", 64'(idx), 64'd2);
        @(posedge clock); #1;
        req_valid = '0;
        checkOutput("post_clear_no_wrap_write", 64'(ram_write), 64'd0);
        checkOutput("post_clear_read_enable", 64'(ram_read_enable), 64'd1);
        repeat (10) @(negedge clock);
        checkOutput("clear_drain", 64'(sb_q.size()), 64'h0);

        // Reset in the middle of a clear aborts it; a new clear restarts at address 0
        @(posedge clock); #1;
        clear_start = 1'b1;
        @(posedge clock); #1;
        clear_start = 1'b0;
        setReq(0, 1'b0, 11'd3, '0, '0);
        setReq(2, 1'b0, 11'd4, '0, '0);
        req_valid = 4'b0101;
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clock);
            if (ram_write && ram_address == 11'd300) hit = 1'b1;
        end
        if (!hit) failNow("reach_addr_300");
        resetn = 1'b0;
        #1;
        checkAllZero("midclear_reset");
        req_valid = '0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("after_reset_busy", 64'(clear_busy), 64'd0);
        @(posedge clock); #1;
        clear_start = 1'b1;
        @(posedge clock); #1;
        clear_start = 1'b0;
        @(posedge clock); #1;
        checkOutput("restart_write0", 64'(ram_write), 64'd1);
        checkOutput("restart_addr0", 64'(ram_address), 64'd0);
        @(posedge clock); #1;
        checkOutput("restart_addr1", 64'(ram_address), 64'd1);
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clock);
            if (!clear_busy) done = 1'b1;
        end
        if (!done) failNow("restart_clear_end");

        repeat (10) @(negedge clock);
        checkOutput("final_drain", 64'(sb_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dla_hld_ram_port_arbiter.md
Name: dla_hld_ram_port_arbiter

Overview:
- Shares one port (a or b) of a dla_hld_ram instance between NUM_REQ requesters, using round-robin arbitration with a valid/ready handshake per requester.
- Tracks outstanding reads with a latency-matched ID pipeline, so each read response is returned only to the requester that issued it.
- Contains a built-in clear sequencer that zero-fills the whole memory on command; this is used at layer start when ZERO_INITIALIZE_MEM cannot be relied on.
- Sits between the DLA feature/filter fetch engines and the RAM hierarchy.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DEPTH, 1024: RAM depth in words. Any multiple of MIN_PHYSICAL_DEPTH is legal (e.g. 1536); it does not have to be a power of 2.
- WIDTH, 40: data width in bits; must be a multiple of 10.
- BE_WIDTH, 4: byte-enable width; must equal WIDTH/10.
- READ_LATENCY, 3: cycles from ram_read_enable to valid ram_readdata. Must match the RAM's REGISTER_*_ADDRESS and REGISTER_*_READDATA configuration; legal range 1..4.
- Localparams: ADDR = $clog2(DEPTH); ID = $clog2(NUM_REQ), minimum 1.

Ports:
- clock, in, 1: sole clock.
- resetn, in, 1: asynchronous, active-low reset.
- clear_start, in, 1: single-cycle request to zero-fill the memory.
- clear_busy, out, 1: high while the clear sequence is running.
- req_valid, in, NUM_REQ: request valid, one bit per requester.
- req_ready, out, NUM_REQ: grant / accept, one-hot or zero.
- req_write, in, NUM_REQ: 1 = write, 0 = read.
- req_address, in, NUM_REQ*ADDR: packed addresses; requester i occupies bits [i*ADDR +: ADDR].
- req_writedata, in, NUM_REQ*WIDTH: packed write data.
- req_byteenable, in, NUM_REQ*BE_WIDTH: packed byte enables.
- rsp_valid, out, NUM_REQ: read-response valid, one-hot or zero.
- rsp_readdata, out, WIDTH: read data, shared by all requesters and qualified by rsp_valid.
- ram_address, out, ADDR: to the RAM port.
- ram_read_enable, out, 1: to the RAM port.
- ram_write, out, 1: to the RAM port.
- ram_writedata, out, WIDTH: to the RAM port.
- ram_byteenable, out, BE_WIDTH: to the RAM port.
- ram_readdata, in, WIDTH: from the RAM port.

Behaviour:
- Reset (async assert, sync deassert in the system):
  - state = ARB, round-robin pointer = 0, ID pipeline cleared.
  - All outputs are 0: req_ready, rsp_valid, rsp_readdata, clear_busy, and every ram_* output.
- States:
  - ARB: normal arbitration.
  - CLEAR: zero-fill in progress.
- ARB arbitration:
  - req_ready is combinational from req_valid and the pointer. Search starts at index ptr and wraps; the first valid requester is granted.
  - Accept condition: req_valid[i] && req_ready[i].
  - On accept, the pointer becomes (i+1) mod NUM_REQ. If nothing is accepted, the pointer holds.
  - A requester holds valid and all of its fields stable until it sees ready.
- RAM command timing:
  - ram_* outputs are registered; a command accepted in cycle t appears on ram_* in cycle t+1.
  - Accepted write: ram_write=1, ram_read_enable=0, with address, data and byteenable copied from the requester.
  - Accepted read: ram_read_enable=1, ram_write=0, ram_writedata=0, ram_byteenable=0.
  - Idle cycle: ram_write=0 and ram_read_enable=0. Address and data hold their previous values; they are don't-care.
- Read response:
  - The ID pipeline is READ_LATENCY deep plus one register stage; each stage holds {valid, ID}.
  - rsp_valid[id] and rsp_readdata (registered copy of ram_readdata) are asserted in cycle t+2+READ_LATENCY for a read accepted in cycle t.
  - Total latency is 5 cycles at the default READ_LATENCY.
  - No back-pressure on responses: requesters must always accept them.
- Throughput and ordering:
  - One command per cycle.
  - Responses are returned in issue order.
  - A write followed by a read to the same address is ordered by the single port, so the read returns the new data.
- Clear sequence:
  - clear_start while in ARB: that cycle's arbitration still completes normally. The next cycle the block enters CLEAR with clear_busy=1.
  - In CLEAR: req_ready=0. One write per cycle goes to addresses 0..DEPTH-1 with data 0 and byteenable all ones; ram_write=1 for exactly DEPTH consecutive cycles.
  - After the write to DEPTH-1 has been issued, the block returns to ARB. clear_busy falls in the same cycle the last clear write appears on ram_*.
  - clear_start while in CLEAR is ignored.
  - Reads accepted before the clear still return their responses normally while CLEAR is running.
- Reset mid-clear: the clear is aborted, the address counter is reset and the state returns to ARB. There is no automatic restart.
- The clear address counter is ADDR bits wide. It stops at DEPTH-1 and never wraps, including for non-power-of-2 DEPTH.

Decomposition:
- Package dla_hld_ram_arb_pkg:
  - state enum {ARB, CLEAR}.
  - A function computing the ID width from NUM_REQ.
  - A struct for a response-pipeline stage {valid, id}.
- Sub-module dla_hld_ram_rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: clock, resetn, req, enable. Outputs: one-hot grant and encoded grant_id.
  - Owns the rotating pointer.
  - Reused elsewhere for other shared DLA resources.

Test Plan:
- Reset → all outputs 0. Then req_valid=4'b1111 with reads to addresses 10,11,12,13 → grants in order 0,1,2,3 on consecutive cycles; rsp_valid one-hot 0001,0010,0100,1000 starting 5 cycles after the first accept.
- Requester 2 writes 40'hAB_CDEF_0123 to address 7 with be=4'b1111, then requester 1 reads address 7 → rsp_valid[1] with rsp_readdata=40'hAB_CDEF_0123. Then requester 2 writes address 7 with be=4'b0001 → only bits [9:0] change.
- Pointer fairness: requester 0 requests continuously while requester 3 raises valid → requester 3 is granted within NUM_REQ cycles; the accept pattern alternates 0,3,0,3.
- clear_start with DEPTH=1536 → clear_busy high for exactly 1536 cycles; ram_address runs 0..1535 and does not wrap; req_ready=0 throughout; afterwards a read of address 1535 returns 0.
- Read accepted in the same cycle as clear_start → its response still arrives at t+5 with the pre-clear data.
- resetn low at clear address 300 → all outputs 0 immediately; after release the state is ARB and a new clear_start restarts from address 0.
